// File: rtl/probe_frame_gen_if.sv
// Avalon-ST transmit bus between the probe frame generator and the MAC TX FIFO.
// The ready signal has latency 0: a beat transfers in any cycle with valid & ready.
interface probe_frame_gen_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;
  logic [1:0]  tx_empty;
  logic        tx_error;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_sop,
    output tx_eop,
    output tx_empty,
    output tx_error,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_sop,
    input  tx_eop,
    input  tx_empty,
    input  tx_error,
    output tx_ready
  );
endinterface

// File: rtl/probe_frame_gen.sv
// Probe frame generator: emits numbered, timestamped Ethernet frames (no preamble/FCS)
// on a 32-bit Avalon-ST bus. A run sends ctrl_count frames (0 = until stopped) with at
// least ctrl_interval cycles between successive SOP acceptances.
module probe_frame_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int unsigned FRAME_LEN = 60
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ctrl_start,
  input  logic                      ctrl_stop,
  input  logic [31:0]               ctrl_count,
  input  logic [31:0]               ctrl_interval,
  input  logic [63:0]               ts_now,
  probe_frame_gen_if.master         tx,
  output logic                      status_busy,
  output logic                      status_done,
  output logic [31:0]               status_sent
);

  localparam int unsigned NumWords   = (FRAME_LEN + 3) / 4;
  localparam int unsigned EmptyBytes = (4 - (FRAME_LEN % 4)) % 4;
  localparam logic [1:0]  EopEmpty   = 2'(EmptyBytes);
  localparam logic [31:0] EopMask    = 32'hFFFF_FFFF << (8 * EmptyBytes);
  localparam logic [10:0] LastIdx    = 11'(NumWords - 1);

  typedef enum logic [1:0] {StIdle, StGap, StSend} state_e;

  state_e      state_q;
  logic [10:0] widx_q;
  logic [31:0] seq_q;
  logic [31:0] sent_q;
  logic [31:0] count_q;
  logic [31:0] interval_q;
  logic [31:0] timer_q;
  logic [63:0] ts_q;
  logic        stop_q;
  logic        done_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        sop_q;
  logic        eop_q;
  logic [1:0]  empty_q;

  logic        beat_acc;
  logic        sop_acc;
  logic        last_acc;
  logic        stop_seen;
  logic        gap_over;
  logic        count_hit;
  logic [10:0] next_idx;
  logic [31:0] next_word;
  logic [31:0] first_word;
  logic [31:0] timer_d;

  // Big-endian frame word at index idx; bytes past FRAME_LEN in the last word are zeroed.
  function automatic logic [31:0] frame_word(input logic [10:0] idx,
                                             input logic [31:0] seq,
                                             input logic [63:0] ts);
    logic [31:0] w;
    case (idx)
      11'd0:   w = DST_MAC[47:16];
      11'd1:   w = {DST_MAC[15:0], SRC_MAC[47:32]};
      11'd2:   w = SRC_MAC[31:0];
      11'd3:   w = {ETHERTYPE, seq[31:16]};
      11'd4:   w = {seq[15:0], ts[63:48]};
      11'd5:   w = ts[47:16];
      11'd6:   w = {ts[15:0], 16'h0000};
      default: w = 32'h0;
    endcase
    if (idx == LastIdx) begin
      w = w & EopMask;
    end
    return w;
  endfunction

  // Handshake decode, interval timer next value and next beat contents.
  always_comb begin
    beat_acc   = valid_q & tx.tx_ready;
    sop_acc    = beat_acc & sop_q;
    last_acc   = beat_acc & (widx_q == LastIdx);
    stop_seen  = stop_q | ctrl_stop;
    // Timer reaches 0 by the next cycle, so an SOP may be presented then.
    gap_over   = (timer_q <= 32'd1);
    count_hit  = (count_q != 32'd0) && ((sent_q + 32'd1) == count_q);
    next_idx   = widx_q + 11'd1;
    next_word  = frame_word(next_idx, seq_q, ts_q);
    first_word = frame_word(11'd0, seq_q, ts_q);
    if (sop_acc) begin
      timer_d = (interval_q == 32'd0) ? 32'd0 : interval_q - 32'd1;
    end else begin
      timer_d = (timer_q == 32'd0) ? 32'd0 : timer_q - 32'd1;
    end
  end

  // Run-control FSM with registered bus and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      widx_q     <= '0;
      seq_q      <= '0;
      sent_q     <= '0;
      count_q    <= '0;
      interval_q <= '0;
      timer_q    <= '0;
      ts_q       <= '0;
      stop_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      empty_q    <= '0;
    end else begin
      timer_q <= timer_d;
      if (sop_acc) begin
        ts_q <= ts_now;
      end
      case (state_q)
        StIdle: begin
          // A simultaneous stop cancels the start outright.
          if (ctrl_start && !ctrl_stop) begin
            count_q    <= ctrl_count;
            interval_q <= ctrl_interval;
            seq_q      <= '0;
            sent_q     <= '0;
            done_q     <= 1'b0;
            stop_q     <= 1'b0;
            if (gap_over) begin
              state_q <= StSend;
              widx_q  <= '0;
              data_q  <= first_word;
              valid_q <= 1'b1;
              sop_q   <= 1'b1;
            end else begin
              state_q <= StGap;
            end
          end
        end
        StGap: begin
          if (stop_seen) begin
            state_q <= StIdle;
            stop_q  <= 1'b0;
          end else if (gap_over) begin
            state_q <= StSend;
            widx_q  <= '0;
            data_q  <= first_word;
            valid_q <= 1'b1;
            sop_q   <= 1'b1;
          end
        end
        StSend: begin
          if (ctrl_stop) begin
            stop_q <= 1'b1;
          end
          if (last_acc) begin
            seq_q   <= seq_q + 32'd1;
            sent_q  <= sent_q + 32'd1;
            widx_q  <= '0;
            eop_q   <= 1'b0;
            empty_q <= '0;
            if (stop_seen || count_hit) begin
              state_q <= StIdle;
              stop_q  <= 1'b0;
              done_q  <= count_hit;
              data_q  <= '0;
              valid_q <= 1'b0;
              sop_q   <= 1'b0;
            end else if (gap_over) begin
              // Back-to-back: next SOP is presented right after EOP acceptance.
              data_q  <= first_word;
              sop_q   <= 1'b1;
            end else begin
              state_q <= StGap;
              data_q  <= '0;
              valid_q <= 1'b0;
              sop_q   <= 1'b0;
            end
          end else if (beat_acc) begin
            widx_q  <= next_idx;
            data_q  <= next_word;
            sop_q   <= 1'b0;
            eop_q   <= (next_idx == LastIdx);
            empty_q <= (next_idx == LastIdx) ? EopEmpty : 2'd0;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          sop_q   <= 1'b0;
          eop_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_data   = data_q;
  assign tx.tx_valid  = valid_q;
  assign tx.tx_sop    = sop_q;
  assign tx.tx_eop    = eop_q;
  assign tx.tx_empty  = empty_q;
  assign tx.tx_error  = 1'b0;
  assign status_busy  = (state_q != StIdle);
  assign status_done  = done_q;
  assign status_sent  = sent_q;

endmodule

// File: tb/tb_probe_frame_gen.sv
// Directed bench for probe_frame_gen: a 60-byte instance covers run control, timing,
// back-pressure and reset; a 61-byte instance covers the partial last beat.
module tb_probe_frame_gen;
  localparam int unsigned LenA = 60;
  localparam int unsigned NwA  = 15;
  localparam int unsigned LenB = 61;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] ts_now = 64'h0123_4567_89AB_CDEF;
  int unsigned cyc = 0;
  logic        start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
  logic [31:0] ctrl_count = '0, ctrl_interval = '0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] sent_a, sent_b;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state for instance A.
  int          mon_idx = 0;
  int          mon_frames = 0;
  logic [63:0] mon_ts = '0;
  int unsigned sop_cyc[$];

  probe_frame_gen_if tx_a ();
  probe_frame_gen_if tx_b ();

  always #5 clk = ~clk;
  always @(posedge clk) begin
    ts_now <= ts_now + 64'd1;
    cyc    <= cyc + 1;
  end

  probe_frame_gen #(.FRAME_LEN(LenA)) dut_a (
    .clk           (clk),
    .reset         (reset),
    .ctrl_start    (start_a),
    .ctrl_stop     (stop_a),
    .ctrl_count    (ctrl_count),
    .ctrl_interval (ctrl_interval),
    .ts_now        (ts_now),
    .tx            (tx_a.master),
    .status_busy   (busy_a),
    .status_done   (done_a),
    .status_sent   (sent_a)
  );

  probe_frame_gen #(.FRAME_LEN(LenB)) dut_b (
    .clk           (clk),
    .reset         (reset),
    .ctrl_start    (start_b),
    .ctrl_stop     (stop_b),
    .ctrl_count    (ctrl_count),
    .ctrl_interval (ctrl_interval),
    .ts_now        (ts_now),
    .tx            (tx_b.master),
    .status_busy   (busy_b),
    .status_done   (done_b),
    .status_sent   (sent_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference byte k of a frame of length len.
  function automatic logic [7:0] ref_byte(input int len, input int k, input logic [31:0] seq,
                                          input logic [63:0] ts);
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] eth;
    dst = 48'hFFFF_FFFF_FFFF;
    src = 48'h0200_0000_0001;
    eth = 16'h88B5;
    if (k >= len)     return 8'h00;
    else if (k < 6)   return dst[8*(5-k) +: 8];
    else if (k < 12)  return src[8*(11-k) +: 8];
    else if (k < 14)  return eth[8*(13-k) +: 8];
    else if (k < 18)  return seq[8*(17-k) +: 8];
    else if (k < 26)  return ts[8*(25-k) +: 8];
    else              return 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input int len, input int idx, input logic [31:0] seq,
                                           input logic [63:0] ts);
    return {ref_byte(len, 4*idx, seq, ts), ref_byte(len, 4*idx+1, seq, ts),
            ref_byte(len, 4*idx+2, seq, ts), ref_byte(len, 4*idx+3, seq, ts)};
  endfunction

  // Watches instance A at the falling edge: hold-while-stalled and golden beat contents.
  task automatic monitor();
    logic        held;
    logic [31:0] hd;
    logic        hs, he;
    logic [1:0]  hm;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_idx = 0;
        held = 1'b0;
      end else begin
        if (held) begin
          check_eq("hold_valid", tx_a.tx_valid, 1);
          check_eq("hold_data", tx_a.tx_data, hd);
          check_eq("hold_sop", tx_a.tx_sop, hs);
          check_eq("hold_eop", tx_a.tx_eop, he);
          check_eq("hold_empty", tx_a.tx_empty, hm);
        end
        held = tx_a.tx_valid && !tx_a.tx_ready;
        hd = tx_a.tx_data;
        hs = tx_a.tx_sop;
        he = tx_a.tx_eop;
        hm = tx_a.tx_empty;
        if (tx_a.tx_valid && tx_a.tx_ready) begin
          check_eq("beat_sop", tx_a.tx_sop, mon_idx == 0);
          if (tx_a.tx_sop) begin
            mon_ts = ts_now;
            sop_cyc.push_back(cyc);
          end
          check_eq("beat_data", tx_a.tx_data, ref_word(LenA, mon_idx, mon_frames, mon_ts));
          check_eq("beat_eop", tx_a.tx_eop, mon_idx == NwA - 1);
          check_eq("beat_empty", tx_a.tx_empty, 0);
          if (tx_a.tx_eop) begin
            mon_frames++;
            mon_idx = 0;
          end else begin
            mon_idx++;
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [31:0] cnt, input logic [31:0] ivl);
    ctrl_count    = cnt;
    ctrl_interval = ivl;
    mon_frames    = 0;
    sop_cyc.delete();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic pulse_stop_a();
    stop_a = 1'b1;
    tick(1);
    stop_a = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy_a; i++) tick(1);
    check_eq("idle_in_time", busy_a, 0);
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && mon_frames < n; i++) tick(1);
    check_eq("frames_in_time", mon_frames >= n, 1);
  endtask

  initial begin
    logic [31:0] wb [0:31];
    logic        eb [0:31];
    logic [1:0]  mb [0:31];
    int          nb;
    int          at;

    tx_a.tx_ready = 1'b1;
    tx_b.tx_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    tick(3);
    check_eq("rst_valid", tx_a.tx_valid, 0);
    check_eq("rst_sop_eop", {tx_a.tx_sop, tx_a.tx_eop}, 0);
    check_eq("rst_data", tx_a.tx_data, 0);
    check_eq("rst_status", {busy_a, done_a, sent_a}, 0);
    reset = 1'b0;
    tick(2);

    // 1: three frames, 100-cycle SOP spacing
    start_run(32'd3, 32'd100);
    check_eq("first_valid", {tx_a.tx_valid, tx_a.tx_sop}, 2'b11);
    wait_idle(1000);
    check_eq("t1_frames", mon_frames, 3);
    check_eq("t1_gap0", (sop_cyc.size() == 3) ? sop_cyc[1] - sop_cyc[0] : 0, 100);
    check_eq("t1_gap1", (sop_cyc.size() == 3) ? sop_cyc[2] - sop_cyc[1] : 0, 100);
    check_eq("t1_done", done_a, 1);
    check_eq("t1_sent", sent_a, 3);

    // 2: 61-byte frame on instance B
    ctrl_count    = 32'd1;
    ctrl_interval = 32'd0;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx_b.tx_valid && nb < 32) begin
        wb[nb] = tx_b.tx_data;
        eb[nb] = tx_b.tx_eop;
        mb[nb] = tx_b.tx_empty;
        nb++;
      end
      tick(1);
    end
    check_eq("t2_beats", nb, 16);
    check_eq("t2_w0", wb[0], 32'hFFFF_FFFF);
    check_eq("t2_w3", wb[3], 32'h88B5_0000);
    check_eq("t2_last_eop", eb[15], 1);
    check_eq("t2_last_empty", mb[15], 3);
    check_eq("t2_last_low", wb[15] & 32'h00FF_FFFF, 0);
    check_eq("t2_done", {busy_b, done_b, sent_b}, {2'b01, 32'd1});

    // 3: random back-pressure, two frames
    start_run(32'd2, 32'd0);
    for (int i = 0; i < 600 && busy_a; i++) begin
      tx_a.tx_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    tx_a.tx_ready = 1'b1;
    check_eq("t3_idle", busy_a, 0);
    check_eq("t3_frames", mon_frames, 2);
    check_eq("t3_sent_done", {done_a, sent_a}, {1'b1, 32'd2});

    // 4: continuous back-to-back, then stop mid-frame
    start_run(32'd0, 32'd0);
    wait_frames(3, 200);
    check_eq("t4_b2b0", (sop_cyc.size() >= 3) ? sop_cyc[1] - sop_cyc[0] : 0, NwA);
    check_eq("t4_b2b1", (sop_cyc.size() >= 3) ? sop_cyc[2] - sop_cyc[1] : 0, NwA);
    for (int i = 0; i < 40 && !(tx_a.tx_valid && tx_a.tx_sop); i++) tick(1);
    tick(3);
    at = mon_frames;
    pulse_stop_a();
    wait_idle(100);
    check_eq("t4_completed", mon_frames, at + 1);
    check_eq("t4_no_partial", mon_idx, 0);
    check_eq("t4_done", done_a, 0);

    // stop while waiting in the gap
    start_run(32'd0, 32'd100);
    wait_frames(1, 100);
    tick(1);
    pulse_stop_a();
    check_eq("gap_stop_busy", busy_a, 0);
    tick(150);
    check_eq("gap_stop_sops", sop_cyc.size(), 1);

    // 5: reset mid-frame, then restart from seq 0
    start_run(32'd0, 32'd0);
    tick(5);
    reset = 1'b1;
    #1;
    check_eq("t5_drop", {tx_a.tx_valid, tx_a.tx_sop, tx_a.tx_eop, busy_a}, 0);
    tick(2);
    reset = 1'b0;
    tick(1);
    check_eq("t5_sent_clr", sent_a, 0);
    start_run(32'd1, 32'd0);
    wait_idle(100);
    check_eq("t5_frames", mon_frames, 1);
    check_eq("t5_sent", sent_a, 1);

    // 6: start while busy is ignored; start+stop in idle sends nothing
    start_run(32'd2, 32'd50);
    tick(3);
    ctrl_count = 32'd5;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    wait_idle(400);
    check_eq("t6_frames", mon_frames, 2);
    check_eq("t6_sent", sent_a, 2);
    sop_cyc.delete();
    start_a = 1'b1;
    stop_a  = 1'b1;
    tick(1);
    start_a = 1'b0;
    stop_a  = 1'b0;
    check_eq("t6_ss_busy", busy_a, 0);
    tick(20);
    check_eq("t6_ss_sops", sop_cyc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
